// File: rtl/clk_ratio_pkg.sv
// Shared types and sizes for the divided-clock ratio monitor.
// Holds the monitor state encoding, counter widths and the legal divide-ratio list.
package clk_ratio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACQUIRE,
      ST_TRACK,
      ST_LOCKED
   } state_t;

   localparam int RATIO_W  = 6;
   localparam int PERIOD_W = 7;
   localparam int ERRCNT_W = 8;
   localparam int GOOD_W   = 8;

   // Only power-of-two ratios from 2 to 32 can be checked.
   function automatic logic isLegalRatio(input logic [RATIO_W-1:0] ratio);
      case (ratio)
         6'd2, 6'd4, 6'd8, 6'd16, 6'd32: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/clk_ratio_monitor_if.sv
// Signal bundle between a driver of the divided clock and the ratio monitor.
// The master side drives the monitored clock and configuration; the slave side reports status.
interface clk_ratio_monitor_if;
   import clk_ratio_pkg::*;

   logic                enable;
   logic                div_in;
   logic [RATIO_W-1:0]  cfg_ratio;
   logic                locked;
   logic                err;
   logic [ERRCNT_W-1:0] err_count;
   logic                cfg_err;
   logic [PERIOD_W-1:0] measured_period;

   modport master (
      output enable, div_in, cfg_ratio,
      input  locked, err, err_count, cfg_err, measured_period
   );

   modport slave (
      input  enable, div_in, cfg_ratio,
      output locked, err, err_count, cfg_err, measured_period
   );

endinterface

// File: rtl/edge_detect_sync.sv
// Two-flop stage for the divided clock with single-cycle rise and fall strobes.
// o_level is the first-stage value, which is what the high-time counter follows.
module edge_detect_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_div,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_divQ;
   logic r_divQQ;

   // Edges are judged between the two stages so both strobes are glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_divQ  <= 1'b0;
         r_divQQ <= 1'b0;
      end else begin
         r_divQ  <= i_div;
         r_divQQ <= r_divQ;
      end
   end

   assign o_level = r_divQ;
   assign o_rise  = r_divQ & ~r_divQQ;
   assign o_fall  = ~r_divQ & r_divQQ;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Checks that a synchronously generated divided clock has the configured period and 50% duty.
// Reports lock after LOCK_CYCLES good periods, pulses err per fault and counts faults.
module clk_ratio_monitor
   import clk_ratio_pkg::*;
#(
   parameter int MAX_PERIOD  = 64,
   parameter int LOCK_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   clk_ratio_monitor_if.slave bus
);

   localparam logic [PERIOD_W-1:0] MaxPeriod  = PERIOD_W'(MAX_PERIOD);
   localparam logic [GOOD_W-1:0]   LockCycles = GOOD_W'(LOCK_CYCLES);

   logic w_divQ;
   logic w_rise;
   logic w_fall;

   logic [PERIOD_W-1:0] r_periodCnt;
   logic [PERIOD_W-1:0] r_highCnt;
   state_t              r_state;
   logic [RATIO_W-1:0]  r_shadow;
   logic [GOOD_W-1:0]   r_goodCnt;
   logic [ERRCNT_W-1:0] r_errCount;
   logic [PERIOD_W-1:0] r_measured;
   logic                r_locked;
   logic                r_err;
   logic                r_cfgErr;

   logic w_checking;
   logic w_periodOk;
   logic w_highOk;
   logic w_timeout;
   logic w_fault;
   logic w_cfgLegal;

   edge_detect_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_div   (bus.div_in),
      .o_level (w_divQ),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   // Counters run in every state so a measurement is already valid when tracking starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_periodCnt <= '0;
         r_highCnt   <= '0;
      end else begin
         if (w_rise)
            r_periodCnt <= PERIOD_W'(1);
         else if (r_periodCnt != MaxPeriod)
            r_periodCnt <= r_periodCnt + PERIOD_W'(1);

         if (w_rise)
            r_highCnt <= PERIOD_W'(1);
         else if (w_divQ && (r_highCnt != '1))
            r_highCnt <= r_highCnt + PERIOD_W'(1);
      end
   end

   assign w_checking = (r_state == ST_TRACK) || (r_state == ST_LOCKED);
   assign w_periodOk = (r_periodCnt == {1'b0, r_shadow});
   assign w_highOk   = (r_highCnt == {2'b00, r_shadow[RATIO_W-1:1]});
   assign w_timeout  = w_checking && !w_rise && (r_periodCnt == MaxPeriod);
   assign w_fault    = w_timeout
                     || (w_checking && w_rise && !w_periodOk)
                     || (w_checking && w_fall && !w_highOk);
   assign w_cfgLegal = isLegalRatio(bus.cfg_ratio);

   // A timeout means the clock has gone away, so tracking restarts from acquisition.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_shadow   <= '0;
         r_goodCnt  <= '0;
         r_errCount <= '0;
         r_measured <= '0;
         r_locked   <= 1'b0;
         r_err      <= 1'b0;
         r_cfgErr   <= 1'b0;
      end else begin
         r_err    <= 1'b0;
         r_cfgErr <= 1'b0;
         if (!bus.enable) begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_cfgLegal) begin
                     r_state  <= ST_ACQUIRE;
                     r_shadow <= bus.cfg_ratio;
                  end else begin
                     r_cfgErr <= 1'b1;
                  end
               end
               ST_ACQUIRE: begin
                  if (w_rise) begin
                     r_state   <= ST_TRACK;
                     r_goodCnt <= '0;
                  end
               end
               ST_TRACK, ST_LOCKED: begin
                  if (w_rise)
                     r_measured <= r_periodCnt;
                  if (w_fault) begin
                     r_err     <= 1'b1;
                     r_goodCnt <= '0;
                     r_locked  <= 1'b0;
                     r_state   <= w_timeout ? ST_ACQUIRE : ST_TRACK;
                     if (r_errCount != '1)
                        r_errCount <= r_errCount + ERRCNT_W'(1);
                  end else if (w_rise) begin
                     if (r_goodCnt < LockCycles)
                        r_goodCnt <= r_goodCnt + GOOD_W'(1);
                     if (r_goodCnt >= LockCycles - GOOD_W'(1)) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.locked          = r_locked;
   assign bus.err             = r_err;
   assign bus.err_count       = r_errCount;
   assign bus.cfg_err         = r_cfgErr;
   assign bus.measured_period = r_measured;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Scenario bench for clk_ratio_monitor with an event-timestamp reference model.
// The model tracks rise/fall times of the sampled divided clock instead of counters.
module tb_clk_ratio_monitor;

   localparam int MAXP  = 64;
   localparam int LOCKC = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   clk_ratio_monitor_if bus();

   clk_ratio_monitor #(.MAX_PERIOD(MAXP), .LOCK_CYCLES(LOCKC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef enum {M_IDLE, M_ACQ, M_TRACK, M_LOCKED} mstate_t;

   mstate_t     mState = M_IDLE;
   int          edgeNo = 0;
   int          lastRise = -1;
   int          mShadow = 0;
   int          mGood = 0;
   int          mErrCount = 0;
   int          mMeasured = 0;
   logic        seen1 = 1'b0;
   logic        seen2 = 1'b0;
   logic        eLocked = 1'b0;
   logic        eErr = 1'b0;
   logic        eCfgErr = 1'b0;
   logic [17:0] expVec = '0;
   logic [17:0] gotVec;
   int          phase = 0;
   int          illegalList[7] = '{0, 1, 3, 6, 12, 33, 63};

   assign gotVec = {bus.locked, bus.err, bus.cfg_err, bus.err_count, bus.measured_period};

   function automatic bit legalRatio(int r);
      return (r >= 2) && (r <= 32) && ((r & (r - 1)) == 0);
   endfunction

   // One clock edge: capture the inputs present at the edge, then predict the outputs.
   task automatic tick();
      logic r, en, d, rise, fall, tmo, fault;
      int cfg, per, high;
      r   = rst;
      en  = bus.enable;
      d   = bus.div_in;
      cfg = int'(bus.cfg_ratio);
      @(posedge clk);
      edgeNo++;
      if (r) begin
         mState = M_IDLE; lastRise = -1; mShadow = 0; mGood = 0;
         mErrCount = 0; mMeasured = 0; seen1 = 1'b0; seen2 = 1'b0;
         eLocked = 1'b0; eErr = 1'b0; eCfgErr = 1'b0;
      end else begin
         rise = seen1 && !seen2;
         fall = !seen1 && seen2;
         per  = (lastRise < 0) ? MAXP : ((edgeNo - lastRise) < MAXP ? edgeNo - lastRise : MAXP);
         high = edgeNo - lastRise;
         eErr = 1'b0;
         eCfgErr = 1'b0;
         if (!en) begin
            mState = M_IDLE;
         end else begin
            case (mState)
               M_IDLE: begin
                  if (legalRatio(cfg)) begin mState = M_ACQ; mShadow = cfg; end
                  else eCfgErr = 1'b1;
               end
               M_ACQ: if (rise) begin mState = M_TRACK; mGood = 0; end
               default: begin
                  tmo   = !rise && (lastRise >= 0) && ((edgeNo - lastRise) >= MAXP);
                  fault = tmo || (rise && per != mShadow) || (fall && high != mShadow / 2);
                  if (rise) mMeasured = per;
                  if (fault) begin
                     eErr = 1'b1;
                     if (mErrCount < 255) mErrCount++;
                     mGood = 0;
                     mState = tmo ? M_ACQ : M_TRACK;
                  end else if (rise) begin
                     mGood++;
                     if (mGood >= LOCKC) mState = M_LOCKED;
                  end
               end
            endcase
         end
         eLocked = (mState == M_LOCKED);
         if (rise) lastRise = edgeNo;
         seen2 = seen1;
         seen1 = d;
      end
      expVec = {eLocked, eErr, eCfgErr, 8'(mErrCount), 7'(mMeasured)};
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      bus.enable = 1'b0;
      bus.div_in = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.enable = 1'b0;
      bus.div_in = 1'b0;
      bus.cfg_ratio = 6'd4;
      tick();
      tick();
      total++;
      if (gotVec !== 18'd0) begin bad++; $display("[TB] FAIL reset_outputs got=%h exp=%h", gotVec, 18'd0); end
      total++;
      if (gotVec !== expVec) begin bad++; $display("[TB] FAIL reset_model got=%h exp=%h", gotVec, expVec); end
      rst = 1'b0;
      tick();
      total++;
      if (gotVec !== 18'd0) begin bad++; $display("[TB] FAIL reset_idle got=%h exp=%h", gotVec, 18'd0); end
   endtask

   task automatic test_lock_ratio4();
      doReset();
      bus.cfg_ratio = 6'd4;
      bus.enable = 1'b1;
      tick();
      for (int c = 0; c < 40; c++) begin
         bus.div_in = ((c % 4) < 2);
         tick();
         total++;
         if (gotVec !== expVec) begin bad++; $display("[TB] FAIL lock4_cycle c=%0d got=%h exp=%h", c, gotVec, expVec); end
      end
      total++;
      if (bus.locked !== 1'b1) begin bad++; $display("[TB] FAIL lock4_locked got=%b exp=1", bus.locked); end
      total++;
      if (bus.measured_period !== 7'd4) begin bad++; $display("[TB] FAIL lock4_period got=%0d exp=4", bus.measured_period); end
      total++;
      if (bus.err_count !== 8'd0) begin bad++; $display("[TB] FAIL lock4_errcount got=%0d exp=0", bus.err_count); end
   endtask

   task automatic test_period_change();
      int pulses;
      doReset();
      bus.cfg_ratio = 6'd8;
      bus.enable = 1'b1;
      tick();
      for (int c = 0; c < 64; c++) begin
         bus.div_in = ((c % 8) < 4);
         tick();
         total++;
         if (gotVec !== expVec) begin bad++; $display("[TB] FAIL chg_lock c=%0d got=%h exp=%h", c, gotVec, expVec); end
      end
      total++;
      if (bus.locked !== 1'b1) begin bad++; $display("[TB] FAIL chg_prelock got=%b exp=1", bus.locked); end
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         bus.div_in = ((c % 16) < 4);
         tick();
         pulses += int'(bus.err);
         total++;
         if (gotVec !== expVec) begin bad++; $display("[TB] FAIL chg_long c=%0d got=%h exp=%h", c, gotVec, expVec); end
      end
      total++;
      if (pulses !== 1) begin bad++; $display("[TB] FAIL chg_pulses got=%0d exp=1", pulses); end
      total++;
      if (bus.err_count !== 8'd1) begin bad++; $display("[TB] FAIL chg_errcount got=%0d exp=1", bus.err_count); end
      total++;
      if (bus.locked !== 1'b0) begin bad++; $display("[TB] FAIL chg_unlock got=%b exp=0", bus.locked); end
   endtask

   task automatic test_bad_duty();
      int pulses;
      doReset();
      bus.cfg_ratio = 6'd8;
      bus.enable = 1'b1;
      tick();
      pulses = 0;
      for (int c = 0; c < 48; c++) begin
         bus.div_in = ((c % 8) < 3);
         tick();
         pulses += int'(bus.err);
         total++;
         if (gotVec !== expVec) begin bad++; $display("[TB] FAIL duty_cycle c=%0d got=%h exp=%h", c, gotVec, expVec); end
         total++;
         if (bus.locked !== 1'b0) begin bad++; $display("[TB] FAIL duty_locked c=%0d got=%b exp=0", c, bus.locked); end
      end
      total++;
      if (pulses !== 6) begin bad++; $display("[TB] FAIL duty_pulses got=%0d exp=6", pulses); end
   endtask

   task automatic test_timeout();
      int pulses, errAt;
      doReset();
      bus.cfg_ratio = 6'd2;
      bus.enable = 1'b1;
      tick();
      for (int c = 0; c < 16; c++) begin
         bus.div_in = ((c % 2) == 0);
         tick();
         total++;
         if (gotVec !== expVec) begin bad++; $display("[TB] FAIL tmo_lock c=%0d got=%h exp=%h", c, gotVec, expVec); end
      end
      total++;
      if (bus.locked !== 1'b1) begin bad++; $display("[TB] FAIL tmo_prelock got=%b exp=1", bus.locked); end
      pulses = 0;
      errAt = -1;
      bus.div_in = 1'b0;
      for (int c = 0; c < 80; c++) begin
         tick();
         if (bus.err === 1'b1) begin pulses++; errAt = c; end
         total++;
         if (gotVec !== expVec) begin bad++; $display("[TB] FAIL tmo_stall c=%0d got=%h exp=%h", c, gotVec, expVec); end
      end
      total++;
      if (pulses !== 1) begin bad++; $display("[TB] FAIL tmo_pulses got=%0d exp=1", pulses); end
      total++;
      if (errAt !== 63) begin bad++; $display("[TB] FAIL tmo_when got=%0d exp=63", errAt); end
      total++;
      if (bus.err_count !== 8'd1) begin bad++; $display("[TB] FAIL tmo_errcount got=%0d exp=1", bus.err_count); end
      for (int c = 0; c < 16; c++) begin
         bus.div_in = ((c % 2) == 0);
         tick();
         total++;
         if (gotVec !== expVec) begin bad++; $display("[TB] FAIL tmo_relock c=%0d got=%h exp=%h", c, gotVec, expVec); end
      end
      total++;
      if (bus.locked !== 1'b1) begin bad++; $display("[TB] FAIL tmo_relocked got=%b exp=1", bus.locked); end
   endtask

   task automatic test_cfg_err();
      doReset();
      bus.cfg_ratio = 6'd6;
      bus.enable = 1'b1;
      phase = 0;
      for (int c = 0; c < 12; c++) begin
         bus.div_in = ((phase % 4) < 2);
         phase++;
         tick();
         total++;
         if (bus.cfg_err !== 1'b1) begin bad++; $display("[TB] FAIL cfg_flag c=%0d got=%b exp=1", c, bus.cfg_err); end
         total++;
         if (gotVec !== expVec) begin bad++; $display("[TB] FAIL cfg_idle c=%0d got=%h exp=%h", c, gotVec, expVec); end
      end
      bus.cfg_ratio = 6'd4;
      for (int c = 0; c < 32; c++) begin
         bus.div_in = ((phase % 4) < 2);
         phase++;
         tick();
         total++;
         if (gotVec !== expVec) begin bad++; $display("[TB] FAIL cfg_lock c=%0d got=%h exp=%h", c, gotVec, expVec); end
      end
      bus.cfg_ratio = 6'd6;
      for (int c = 0; c < 8; c++) begin
         bus.div_in = ((phase % 4) < 2);
         phase++;
         tick();
         total++;
         if (gotVec !== expVec) begin bad++; $display("[TB] FAIL cfg_ignored c=%0d got=%h exp=%h", c, gotVec, expVec); end
      end
      total++;
      if (bus.locked !== 1'b1 || bus.cfg_err !== 1'b0) begin
         bad++; $display("[TB] FAIL cfg_shadow got=%b%b exp=10", bus.locked, bus.cfg_err);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (gotVec !== 18'd0) begin bad++; $display("[TB] FAIL rst_in_lock got=%h exp=%h", gotVec, 18'd0); end
   endtask

   task automatic test_saturation();
      doReset();
      bus.cfg_ratio = 6'd2;
      bus.enable = 1'b1;
      tick();
      for (int c = 0; c < 640; c++) begin
         bus.div_in = ((c % 4) < 2);
         tick();
         total++;
         if (gotVec !== expVec) begin bad++; $display("[TB] FAIL sat_cycle c=%0d got=%h exp=%h", c, gotVec, expVec); end
      end
      total++;
      if (bus.err_count !== 8'd255) begin bad++; $display("[TB] FAIL sat_count got=%0d exp=255", bus.err_count); end
   endtask

   task automatic test_random();
      int ratio, base, nper, hi, lo, dh, dl;
      doReset();
      for (int r = 0; r < 12; r++) begin
         if ($urandom_range(0, 5) == 5) begin
            ratio = illegalList[$urandom_range(0, 6)];
            base = 4;
         end else begin
            ratio = 2 << $urandom_range(0, 4);
            base = ratio;
         end
         bus.cfg_ratio = 6'(ratio);
         bus.enable = 1'b1;
         tick();
         nper = int'($urandom_range(3, 10));
         for (int p = 0; p < nper; p++) begin
            dh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) - 1 : 0;
            dl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) - 1 : 0;
            hi = (base / 2 + dh < 1) ? 1 : base / 2 + dh;
            lo = (base / 2 + dl < 1) ? 1 : base / 2 + dl;
            if (p == 2) bus.cfg_ratio = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) lo = 70;
            for (int c = 0; c < hi + lo; c++) begin
               bus.div_in = (c < hi);
               tick();
               total++;
               if (gotVec !== expVec) begin bad++; $display("[TB] FAIL rand r=%0d p=%0d c=%0d got=%h exp=%h", r, p, c, gotVec, expVec); end
            end
         end
         bus.enable = 1'b0;
         for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (gotVec !== expVec) begin bad++; $display("[TB] FAIL rand_off r=%0d got=%h exp=%h", r, gotVec, expVec); end
         end
      end
   endtask

   initial begin
      bus.enable = 1'b0;
      bus.div_in = 1'b0;
      bus.cfg_ratio = 6'd4;
      test_reset();
      test_lock_ratio4();
      test_period_change();
      test_bad_duty();
      test_timeout();
      test_cfg_err();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clk_ratio_monitor.md
CLK_RATIO_MONITOR -- requirements
Module: clk_ratio_monitor

Interface
REQ-001 Parameter MAX_PERIOD, default 64, meaning clk cycles without a div_in rising edge before timeout.
REQ-002 Parameter LOCK_CYCLES, default 4, meaning consecutive good periods required to assert locked.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  monitor run; 0 forces IDLE.
REQ-006 div_in  input  1  divided clock under check, generated synchronously from clk.
REQ-007 cfg_ratio  input  6  expected divide ratio; legal values 2, 4, 8, 16, 32.
REQ-008 locked  output  1  LOCK_CYCLES consecutive good periods seen.
REQ-009 err  output  1  one-cycle pulse per detected fault.
REQ-010 err_count  output  8  saturating fault counter.
REQ-011 cfg_err  output  1  cfg_ratio illegal while enable=1.
REQ-012 measured_period  output  7  last measured rise-to-rise period, in clk cycles.

Function
REQ-013 div_in SHALL pass through two flops (div_q, div_qq); rise = div_q & ~div_qq; fall = ~div_q & div_qq.
REQ-014 All outputs SHALL be registered and update on the clk edge at which the rise or fall is detected, i.e. 2 edges after div_in changes.
REQ-015 period_cnt SHALL load 1 on a rise and otherwise increment, saturating at MAX_PERIOD; at a rise its value equals cycles since the previous rise.
REQ-016 high_cnt SHALL load 1 on a rise and increment while div_q=1; at a fall its value equals the high time.
REQ-017 States: IDLE, ACQUIRE, TRACK, LOCKED.
REQ-018 IDLE -> ACQUIRE when enable=1 and cfg_ratio is legal; legal cfg_ratio is sampled into a shadow register on this transition.
REQ-019 ACQUIRE -> TRACK on the first rise; no period check is made on this rise; good-count cleared.
REQ-020 In TRACK/LOCKED, each rise SHALL load measured_period=period_cnt and check period_cnt == shadow ratio.
REQ-021 In TRACK/LOCKED, each fall SHALL check high_cnt == shadow ratio/2.
REQ-022 Good period: increment good-count; TRACK -> LOCKED when good-count reaches LOCK_CYCLES.
REQ-023 Any failed check: err=1 for one cycle, err_count+1 (hold at 255), good-count cleared, LOCKED/TRACK -> TRACK, locked=0.
REQ-024 period_cnt reaching MAX_PERIOD in TRACK/LOCKED: timeout fault, same effects as REQ-023, next state ACQUIRE; in ACQUIRE, no timeout error.
REQ-025 Rise and timeout in the same cycle: rise takes precedence; no timeout fault.
REQ-026 enable=0 from any state -> IDLE next edge; locked=0; err_count and measured_period hold.
REQ-027 Illegal cfg_ratio with enable=1: cfg_err=1, stay or return to IDLE; cfg_ratio changes outside IDLE are ignored (shadow used).

Reset
REQ-028 rst=1 SHALL, on the next clk edge, set state=IDLE and clear locked, err, err_count, cfg_err, measured_period, all counters and the sync flops.
REQ-029 rst SHALL override enable and any in-progress period, including mid-LOCKED.

Structure
REQ-030 State encoding, the legal-ratio list and the counter widths SHALL live in a shared package clk_ratio_pkg.
REQ-031 The edge-detect synchronizer SHALL be one sub-module, edge_detect_sync (outputs rise and fall); the rest is flat.

Verification
REQ-032 cfg_ratio=4, div_in 2 high/2 low, enable=1 -> locked=1 after 4 checked periods; measured_period=4; err_count=0.
REQ-033 Locked at ratio 8, then div_in period changes to 16 -> single err pulse at the first long rise; err_count=1; locked=0.
REQ-034 Ratio 8, div_in 3 high/5 low -> err at each fall; locked stays 0.
REQ-035 div_in stuck at 0 after lock (ratio 2) -> err once at period_cnt=64; state ACQUIRE; err_count=1.
REQ-036 cfg_ratio=6, enable=1 -> cfg_err=1, stays in IDLE; rst pulse while LOCKED -> all outputs 0 next edge.
REQ-037 300 forced faults -> err_count saturates at 255.
